// File: rtl/tracker_sequencer.sv
// rtl/tracker_sequencer.sv - line-tracking car mode sequencer (sensor filter, countdown, follow/junction/turn FSM)
// Optional obstacle input enabled by defining TRACKER_OBSTACLE_EN.
module tracker_sequencer #(
  parameter int COUNT_CYCLES  = 100_000_000,
  parameter int DEB_CYCLES    = 200_000,
  parameter int CHOOSE_CYCLES = 20_000_000,
  parameter int TURN_MIN      = 30_000_000,
  parameter int TURN_MAX      = 200_000_000,
  parameter int LOST_CYCLES   = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       halt,
  input  logic [2:0] sensor,
  input  logic [1:0] turn_pref,
`ifdef TRACKER_OBSTACLE_EN
  input  logic       obstacle,
`endif
  output logic       turn_take,
  output logic [4:0] mode,
  output logic [4:0] last_mode,
  output logic       busy
);

  localparam int MAX_A = (COUNT_CYCLES > CHOOSE_CYCLES) ? COUNT_CYCLES : CHOOSE_CYCLES;
  localparam int MAX_B = (TURN_MIN > TURN_MAX) ? TURN_MIN : TURN_MAX;
  localparam int MAX_C = (LOST_CYCLES > DEB_CYCLES) ? LOST_CYCLES : DEB_CYCLES;
  localparam int MAX_AB = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAXP = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
  localparam int W = $clog2(MAXP + 1);

  localparam logic [W-1:0] ONE       = W'(1);
  localparam logic [W-1:0] COUNT_M1  = W'(COUNT_CYCLES - 1);
  localparam logic [W-1:0] CHOOSE_M1 = W'(CHOOSE_CYCLES - 1);
  localparam logic [W-1:0] DEB_M1    = W'(DEB_CYCLES - 1);
  localparam logic [W-1:0] TMIN      = W'(TURN_MIN);
  localparam logic [W-1:0] TMAX      = W'(TURN_MAX);
  localparam logic [W-1:0] LOST      = W'(LOST_CYCLES);

  typedef enum logic [4:0] {
    S_IDLE     = 5'd0,  S_START  = 5'd1,  S_COUNT  = 5'd2, S_STRAIGHT = 5'd3,
    S_CHOOSE   = 5'd4,  S_LEFT   = 5'd5,  S_RIGHT  = 5'd6, S_BACK     = 5'd7,
    S_LLEFT    = 5'd8,  S_LRIGHT = 5'd9,  S_STOP   = 5'd30, S_ERROR   = 5'd31
  } state_t;

  state_t state, state_nx;
  logic [W-1:0] timer, timer_nx, lost, lost_nx, deb_cnt;
  logic [2:0] sync1, sync2, deb_pat, sns_f;
  logic take_nx;
  logic is_follow;

  // Synchronise raw sensors, then accept a pattern only once it has held DEB_CYCLES samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 3'b000;
      sync2   <= 3'b000;
      deb_pat <= 3'b000;
      deb_cnt <= '0;
      sns_f   <= 3'b000;
    end else begin
      sync1 <= sensor;
      sync2 <= sync1;
      if (sync2 != deb_pat) begin
        deb_pat <= sync2;
        deb_cnt <= ONE;
      end else if (deb_cnt >= DEB_M1) begin
        sns_f <= deb_pat;
      end else begin
        deb_cnt <= deb_cnt + ONE;
      end
    end
  end

`ifdef TRACKER_OBSTACLE_EN
  logic obs_1, obs_s;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      obs_1 <= 1'b0;
      obs_s <= 1'b0;
    end else begin
      obs_1 <= obstacle;
      obs_s <= obs_1;
    end
  end
`endif

  assign is_follow = (state == S_STRAIGHT) || (state == S_LLEFT) || (state == S_LRIGHT);

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    lost_nx  = lost;
    take_nx  = 1'b0;
    if (halt && state != S_IDLE) begin
      state_nx = S_STOP;
    end
`ifdef TRACKER_OBSTACLE_EN
    else if (obs_s && (is_follow || state == S_CHOOSE)) begin
      state_nx = S_BACK;
      timer_nx = '0;
    end
`endif
    else begin
      case (state)
        S_IDLE, S_STOP, S_ERROR: if (start) state_nx = S_START;
        S_START: begin
          state_nx = S_COUNT;
          timer_nx = COUNT_M1;
          lost_nx  = '0;
        end
        S_COUNT: begin
          if (timer == '0) state_nx = S_STRAIGHT;
          else timer_nx = timer - ONE;
        end
        S_STRAIGHT, S_LLEFT, S_LRIGHT: begin
          if (sns_f != 3'b000) lost_nx = '0;
          case (sns_f)
            3'b010:         state_nx = S_STRAIGHT;
            3'b100, 3'b110: state_nx = S_LLEFT;
            3'b001, 3'b011: state_nx = S_LRIGHT;
            3'b111: begin
              state_nx = S_CHOOSE;
              timer_nx = CHOOSE_M1;
            end
            3'b000: begin
              if (lost == LOST) state_nx = S_ERROR;
              else lost_nx = lost + ONE;
            end
            default: ;
          endcase
        end
        S_CHOOSE: begin
          if (timer == '0) begin
            take_nx = 1'b1;
            case (turn_pref)
              2'b00: state_nx = S_STRAIGHT;
              2'b01: state_nx = S_LEFT;
              2'b10: state_nx = S_RIGHT;
              2'b11: state_nx = S_BACK;
            endcase
          end else begin
            timer_nx = timer - ONE;
          end
        end
        S_LEFT, S_RIGHT, S_BACK: begin
          // Middle sensor may only end the turn after the minimum time; the timer saturates at TURN_MAX.
          if (timer >= TMIN && sns_f[1]) state_nx = S_STRAIGHT;
          else if (timer >= TMAX) state_nx = S_ERROR;
          else timer_nx = timer + ONE;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      lost      <= '0;
      turn_take <= 1'b0;
      last_mode <= 5'd0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      timer     <= timer_nx;
      lost      <= lost_nx;
      turn_take <= take_nx;
      if (state_nx != state) last_mode <= state;
      busy <= !(state_nx == S_IDLE || state_nx == S_STOP || state_nx == S_ERROR);
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_tracker_sequencer.sv
// tb/tb_tracker_sequencer.sv - directed vector and sequence bench for tracker_sequencer
module tb_tracker_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       halt = 1'b0;
  logic [2:0] sensor = 3'b010;
  logic [1:0] turn_pref = 2'b00;
  logic       turn_take;
  logic [4:0] mode;
  logic [4:0] last_mode;
  logic       busy;
`ifdef TRACKER_OBSTACLE_EN
  logic       obstacle = 1'b0;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tracker_sequencer #(
    .COUNT_CYCLES(10), .DEB_CYCLES(2), .CHOOSE_CYCLES(5),
    .TURN_MIN(8), .TURN_MAX(40), .LOST_CYCLES(12)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .sensor(sensor),
    .turn_pref(turn_pref),
`ifdef TRACKER_OBSTACLE_EN
    .obstacle(obstacle),
`endif
    .turn_take(turn_take), .mode(mode), .last_mode(last_mode), .busy(busy)
  );

  typedef struct {
    logic       start;
    logic       halt;
    logic [2:0] sensor;
    int         exp_mode;
    int         exp_last;
    int         exp_busy;
    int         exp_take;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic ha, input logic [2:0] sn,
                     input int em, input int el, input int eb, input int et);
    vec_t v;
    v.start = st; v.halt = ha; v.sensor = sn;
    v.exp_mode = em; v.exp_last = el; v.exp_busy = eb; v.exp_take = et;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    int n;
    int m;

    repeat (3) tick();
    chk("reset_mode", mode, 0);
    chk("reset_last", last_mode, 0);
    chk("reset_busy", busy, 0);
    chk("reset_take", turn_take, 0);
    rst = 1'b0;

    // halt ignored in IDLE, then start, countdown, and a short LITTLE_LEFT excursion
    add(0, 1, 3'b010, 0, 0, 0, 0);
    add(1, 0, 3'b010, 1, 0, 1, 0);
    for (int i = 2; i <= 11; i++) add(0, 0, 3'b010, 2, 1, 1, 0);
    for (int i = 12; i <= 13; i++) add(0, 0, 3'b010, 3, 2, 1, 0);
    for (int i = 14; i <= 17; i++) add(0, 0, 3'b110, 3, 2, 1, 0);
    for (int i = 18; i <= 21; i++) add(0, 0, 3'b010, 8, 3, 1, 0);
    for (int i = 22; i <= 23; i++) add(0, 0, 3'b010, 3, 8, 1, 0);

    foreach (vecs[i]) begin
      start = vecs[i].start; halt = vecs[i].halt; sensor = vecs[i].sensor;
      tick();
      n_vec++;
      if (mode != vecs[i].exp_mode || last_mode != vecs[i].exp_last ||
          busy != vecs[i].exp_busy || turn_take != vecs[i].exp_take) begin
        n_bad++;
        $display("FAIL vec%0d: mode/last/busy/take got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                 i, mode, last_mode, busy, turn_take, vecs[i].exp_mode, vecs[i].exp_last,
                 vecs[i].exp_busy, vecs[i].exp_take);
      end
    end

    // junction: CHOOSE 5 cycles, left turn held to TURN_MIN despite middle sensor
    sensor = 3'b111; turn_pref = 2'b01;
    n = 0;
    while (mode != 4 && n < 20) begin tick(); n++; end
    chk("enter_choose", mode, 4);
    n = 0;
    while (mode == 4 && n < 20) begin tick(); n++; end
    chk("choose_len", n, 5);
    chk("left_mode", mode, 5);
    chk("left_take", turn_take, 1);
    chk("left_last", last_mode, 4);
    m = 1;
    for (int k = 0; k < 60; k++) begin
      if (m == 2) sensor = 3'b010;
      tick();
      if (k == 0) chk("take_one_cycle", turn_take, 0);
      if (mode != 5) break;
      m++;
    end
    chk("left_len", m, 9);
    chk("after_left_mode", mode, 3);
    chk("after_left_last", last_mode, 5);

    // line lost
    sensor = 3'b000;
    n = 0;
    while (mode == 3 && n < 40) begin tick(); n++; end
    chk("lost_ticks", n, 17);
    chk("lost_mode", mode, 31);
    chk("lost_last", last_mode, 3);
    chk("lost_busy", busy, 0);

    // restart from ERROR, back turn without middle sensor -> TURN_MAX timeout
    sensor = 3'b111; turn_pref = 2'b11; start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_mode", mode, 1);
    chk("restart_last", last_mode, 31);
    for (int k = 0; k < 60; k++) begin
      if (mode == 4) sensor = 3'b101;
      if (mode == 7) break;
      tick();
    end
    chk("back_mode", mode, 7);
    m = 1;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (mode != 7) break;
      m++;
    end
    chk("back_len", m, 41);
    chk("turn_max_mode", mode, 31);
    chk("turn_max_last", last_mode, 7);

    // halt beats start
    sensor = 3'b111; halt = 1'b1; start = 1'b1;
    tick();
    chk("halt_start_mode", mode, 30);
    chk("halt_start_last", last_mode, 31);
    chk("halt_start_busy", busy, 0);
    tick();
    chk("halt_hold_mode", mode, 30);
    halt = 1'b0;
    tick();
    start = 1'b0;
    chk("stop_restart", mode, 1);

    // halt inside CHOOSE: no turn_take
    n = 0;
    while (mode != 4 && n < 40) begin tick(); n++; end
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("halt_choose_mode", mode, 30);
    chk("halt_choose_last", last_mode, 4);
    chk("halt_choose_take", turn_take, 0);

    // async reset mid-turn
    turn_pref = 2'b10; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (mode != 6 && n < 40) begin tick(); n++; end
    chk("right_mode", mode, 6);
    chk("right_take", turn_take, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_mode", mode, 0);
    chk("arst_last", last_mode, 0);
    chk("arst_take", turn_take, 0);
    chk("arst_busy", busy, 0);
    tick();
    rst = 1'b0;

`ifdef TRACKER_OBSTACLE_EN
    sensor = 3'b010; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (mode != 3 && n < 40) begin tick(); n++; end
    obstacle = 1'b1;
    n = 0;
    while (mode == 3 && n < 10) begin tick(); n++; end
    chk("obstacle_mode", mode, 7);
    chk("obstacle_take", turn_take, 0);
    obstacle = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
